// File: rtl/field_pack_serializer_pkg.sv
// Shared constants, state type and word-packing helpers for the 5-bit field packer/serializer.
package field_pack_pkg;

    localparam int FIELD_W    = 5;
    localparam int NUM_FIELDS = 6;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int NUM_BYTES  = 4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } fps_state_t;

    // Slot 0 is field a and lands in word bits [31:27].
    typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0] fields_t;

    function automatic logic [WORD_W-1:0] pack_word(input fields_t fields, input logic [1:0] tail);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            w[WORD_W-1-FIELD_W*i -: FIELD_W] = fields[i];
        end
        w[1:0] = tail;
        return w;
    endfunction

    function automatic logic [BYTE_W-1:0] byte_at(input logic [WORD_W-1:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_at = w[31:24];
            2'd1:    byte_at = w[23:16];
            2'd2:    byte_at = w[15:8];
            2'd3:    byte_at = w[7:0];
            default: byte_at = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/field_pack_serializer_if.sv
// Field input stream and byte output stream of the packer/serializer.
interface field_pack_serializer_if
    import field_pack_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic               in_valid;
    logic [FIELD_W-1:0] in_field;
    logic               in_ready;
    logic               out_valid;
    logic [BYTE_W-1:0]  out_byte;
    logic               out_ready;
    logic               out_last;
    logic [CNT_W-1:0]   groups_done;

    modport master (
        output in_valid, in_field, out_ready,
        input  in_ready, out_valid, out_byte, out_last, groups_done
    );

    modport slave (
        input  in_valid, in_field, out_ready,
        output in_ready, out_valid, out_byte, out_last, groups_done
    );
endinterface

// File: rtl/field_pack_serializer_accum.sv
// Six-slot field accumulator; word_o includes a field being pushed this cycle so the
// completed word is available on the 6th handshake.
module field_pack_accum
    import field_pack_pkg::*;
#(
    parameter logic [1:0] TAIL = 2'b11
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [FIELD_W-1:0] field_i,
    output logic               done_o,
    output logic [WORD_W-1:0]  word_o
);
    localparam logic [2:0] LAST_SLOT = 3'(NUM_FIELDS - 1);

    fields_t    slots_q;
    fields_t    merged_s;
    logic [2:0] fcnt_q;

    // Slot storage and fill counter; slots keep a completed group until overwritten.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slots_q <= '0;
            fcnt_q  <= 3'd0;
        end else if (push_i) begin
            slots_q[fcnt_q] <= field_i;
            fcnt_q          <= (fcnt_q == LAST_SLOT) ? 3'd0 : fcnt_q + 3'd1;
        end
    end

    // Merge the incoming field so the packed word is complete on the final push.
    always_comb begin
        merged_s = slots_q;
        done_o   = 1'b0;
        if (push_i) begin
            merged_s[fcnt_q] = field_i;
            done_o           = (fcnt_q == LAST_SLOT);
        end else begin
            merged_s = slots_q;
            done_o   = 1'b0;
        end
        word_o = pack_word(merged_s, TAIL);
    end

endmodule

// File: rtl/field_pack_serializer.sv
// Packs six 5-bit fields plus TAIL into a 32-bit word and emits it MSB byte first.
// FIELD_PACK_SERIALIZER_OVERLAP_EN adds a second accumulator so collection overlaps emission.
module field_pack_serializer
    import field_pack_pkg::*;
#(
    parameter logic [1:0] TAIL  = 2'b11,
    parameter int         CNT_W = 8
)
(
    input  logic                     clk,
    input  logic                     reset,
    field_pack_serializer_if.slave   bus
);
    fps_state_t         state_q;
    logic [WORD_W-1:0]  word_q;
    logic [1:0]         idx_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [BYTE_W-1:0]  out_byte_q;
    logic               in_ready_q;
    logic [CNT_W-1:0]   groups_q;

    logic               in_hs_s;
    logic               out_hs_s;
    logic               last_hs_s;
    logic               col_done_s;
    logic [WORD_W-1:0]  col_word_s;
    logic               load_en_d;
    logic [WORD_W-1:0]  load_word_d;
    logic               in_ready_d;

    assign in_hs_s   = bus.in_valid & in_ready_q;
    assign out_hs_s  = out_valid_q & bus.out_ready;
    assign last_hs_s = out_hs_s & (idx_q == 2'd3);

`ifdef FIELD_PACK_SERIALIZER_OVERLAP_EN
    logic               sel_q;
    logic               pend_q;
    logic               pend_set_d;
    logic               pend_clr_d;
    logic               sel_flip_d;
    logic               done0_s;
    logic               done1_s;
    logic [WORD_W-1:0]  word0_s;
    logic [WORD_W-1:0]  word1_s;
    logic [WORD_W-1:0]  pend_word_s;

    field_pack_accum #(.TAIL(TAIL)) u_acc0 (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (in_hs_s & ~sel_q),
        .field_i (bus.in_field),
        .done_o  (done0_s),
        .word_o  (word0_s)
    );

    field_pack_accum #(.TAIL(TAIL)) u_acc1 (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (in_hs_s & sel_q),
        .field_i (bus.in_field),
        .done_o  (done1_s),
        .word_o  (word1_s)
    );

    // sel_q names the collecting accumulator; the other one holds any pending group.
    assign col_done_s  = sel_q ? done1_s : done0_s;
    assign col_word_s  = sel_q ? word1_s : word0_s;
    assign pend_word_s = sel_q ? word0_s : word1_s;

    // Decide when a word loads, when a completed group must wait, and next in_ready.
    always_comb begin
        load_en_d   = 1'b0;
        load_word_d = col_word_s;
        pend_set_d  = 1'b0;
        pend_clr_d  = 1'b0;
        sel_flip_d  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_hs_s && col_done_s) begin
                    load_en_d  = 1'b1;
                    sel_flip_d = 1'b1;
                end else begin
                    load_en_d  = 1'b0;
                end
            end
            EMIT: begin
                if (last_hs_s) begin
                    if (pend_q) begin
                        load_en_d   = 1'b1;
                        load_word_d = pend_word_s;
                        pend_clr_d  = 1'b1;
                    end else if (in_hs_s && col_done_s) begin
                        load_en_d  = 1'b1;
                        sel_flip_d = 1'b1;
                    end else begin
                        load_en_d  = 1'b0;
                    end
                end else if (in_hs_s && col_done_s) begin
                    pend_set_d = 1'b1;
                    sel_flip_d = 1'b1;
                end else begin
                    pend_set_d = 1'b0;
                end
            end
            default: begin
                load_en_d = 1'b0;
            end
        endcase
        in_ready_d = ~(pend_set_d | (pend_q & ~pend_clr_d));
    end

    // Pending-group bookkeeping for the overlapped build.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (sel_flip_d) begin
                sel_q <= ~sel_q;
            end
            if (pend_set_d) begin
                pend_q <= 1'b1;
            end else if (pend_clr_d) begin
                pend_q <= 1'b0;
            end
        end
    end
`else
    field_pack_accum #(.TAIL(TAIL)) u_acc0 (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (in_hs_s),
        .field_i (bus.in_field),
        .done_o  (col_done_s),
        .word_o  (col_word_s)
    );

    // Decide when a word loads and whether fields are accepted next cycle.
    always_comb begin
        load_word_d = col_word_s;
        if ((state_q == COLLECT) && in_hs_s && col_done_s) begin
            load_en_d = 1'b1;
        end else begin
            load_en_d = 1'b0;
        end
        in_ready_d = ((state_q == COLLECT) && !load_en_d) || last_hs_s;
    end
`endif

    // Main FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            word_q      <= '0;
            idx_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            groups_q    <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            if (last_hs_s) begin
                groups_q <= groups_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (load_en_d) begin
                state_q     <= EMIT;
                word_q      <= load_word_d;
                idx_q       <= 2'd0;
                out_valid_q <= 1'b1;
                out_byte_q  <= byte_at(load_word_d, 2'd0);
                out_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    COLLECT: begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    EMIT: begin
                        if (out_hs_s) begin
                            if (idx_q == 2'd3) begin
                                state_q     <= COLLECT;
                                idx_q       <= 2'd0;
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                            end else begin
                                idx_q      <= idx_q + 2'd1;
                                out_byte_q <= byte_at(word_q, idx_q + 2'd1);
                                out_last_q <= (idx_q == 2'd2);
                            end
                        end
                    end
                    default: begin
                        state_q     <= COLLECT;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_byte    = out_byte_q;
    assign bus.out_last    = out_last_q;
    assign bus.groups_done = groups_q;

endmodule

// File: tb/tb_field_pack_serializer.sv
// Scoreboard bench for field_pack_serializer: directed cases then randomized traffic.
module tb_field_pack_serializer;
    import field_pack_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    field_pack_serializer_if #(.CNT_W(8)) bus();

    field_pack_serializer #(.TAIL(2'b11), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t       q[$];
    logic [4:0] part[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_groups = 8'd0;
    int         rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word = {a,b,c,d,e,f,2'b11}, bytes taken MSB first.
    function automatic void push_word();
        logic [31:0] w;
        w = {part[0], part[1], part[2], part[3], part[4], part[5], 2'b11};
        for (int i = 0; i < 4; i++) begin
            q.push_back('{b: w[31-8*i -: 8], last: (i == 3)});
        end
    endfunction

    task automatic send_field(input logic [4:0] f, input int gap);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        bus.in_valid = 1'b1;
        bus.in_field = f;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("in_accept", {31'd0, hs}, 32'd1);
        if (hs) begin
            part.push_back(f);
            if (part.size() == 6) begin
                push_word();
                part.delete();
            end
        end
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        part.delete();
        exp_groups = 8'd0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_groups", {24'd0, bus.groups_done}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdy_mode = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pops, hold rule and counter tracking.
    logic       have_prev = 1'b0;
    logic       prev_v, prev_r, prev_l;
    logic [7:0] prev_b;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            check("groups_done", {24'd0, bus.groups_done}, {24'd0, exp_groups});
`ifndef FIELD_PACK_SERIALIZER_OVERLAP_EN
            if (bus.out_valid) check("in_ready_in_emit", {31'd0, bus.in_ready}, 32'd0);
`endif
            if (have_prev && prev_v && !prev_r) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_byte", {24'd0, bus.out_byte}, {24'd0, prev_b});
                check("hold_last", {31'd0, bus.out_last}, {31'd0, prev_l});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", bus.out_byte, $time);
                end else begin
                    e = q.pop_front();
                    check("out_byte", {24'd0, bus.out_byte}, {24'd0, e.b});
                    check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
                    if (e.last) exp_groups = exp_groups + 8'd1;
                end
            end
            prev_v = bus.out_valid;
            prev_r = bus.out_ready;
            prev_b = bus.out_byte;
            prev_l = bus.out_last;
            have_prev = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [4];
        logic [4:0] g2 [6];
        t1 = '{8'h08, 8'h86, 8'h42, 8'h9B};
        g2 = '{5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        bus.in_valid  = 1'b0;
        bus.in_field  = 5'd0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_out_byte", {24'd0, bus.out_byte}, 32'd0);
        check("reset_out_last", {31'd0, bus.out_last}, 32'd0);
        check("reset_groups", {24'd0, bus.groups_done}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("first_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Fields 1..6 back-to-back: bytes on four consecutive cycles.
        for (int i = 1; i <= 6; i++) send_field(5'(i), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
            check("t1_byte", {24'd0, bus.out_byte}, {24'd0, t1[i]});
            check("t1_last", {31'd0, bus.out_last}, (i == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t1_groups", {24'd0, bus.groups_done}, 32'd1);
        @(posedge clk);
        #1;

        // Sparse fields with gaps.
        for (int i = 0; i < 6; i++) send_field(g2[i], 2);
        drain();

        // Back-pressure on byte 86.
        rdy_mode = 2;
        for (int i = 1; i <= 6; i++) send_field(5'(i), 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold86_byte", {24'd0, bus.out_byte}, 32'h86);
            check("hold86_valid", {31'd0, bus.out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        drain();

        // Reset mid-collection, then an all-zero group.
        for (int i = 0; i < 3; i++) send_field(5'($urandom_range(1, 31)), 0);
        do_reset();
        for (int i = 0; i < 6; i++) send_field(5'd0, 0);
        drain();

        // Reset while byte 42 is presented.
        rdy_mode = 2;
        for (int i = 1; i <= 6; i++) send_field(5'(i), 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rdy_mode = 2;
        @(negedge clk);
        check("pre_rst_byte42", {24'd0, bus.out_byte}, 32'h42);
        @(posedge clk);
        #1;
        do_reset();
        rdy_mode = 0;

        // Two groups streamed continuously.
        for (int i = 1; i <= 6; i++) send_field(5'(i), 0);
        for (int i = 0; i < 6; i++) send_field(g2[i], 0);
        drain();
        @(negedge clk);
        check("stream_groups", {24'd0, bus.groups_done}, 32'd2);
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure and one aborted group.
        rdy_mode = 1;
        for (int g = 0; g < 40; g++) begin
            if (g == 20) begin
                send_field(5'($urandom_range(0, 31)), 0);
                send_field(5'($urandom_range(0, 31)), 1);
                do_reset();
                rdy_mode = 1;
            end
            for (int i = 0; i < 6; i++) send_field(5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
